// File: rtl/mcpu_irom_loader_pkg.sv
// mcpu_irom_loader_pkg: loader FSM states, frame sync marker and error codes
package mcpu_irom_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR_H = 3'd1,
    S_ADDR_L = 3'd2,
    S_LEN_H  = 3'd3,
    S_LEN_L  = 3'd4,
    S_DATA   = 3'd5,
    S_CSUM   = 3'd6
  } state_t;
  localparam logic [7:0] MCPU_LOADER_SYNC    = 8'hA5;
  localparam logic [1:0] MCPU_LDERR_NONE     = 2'b00;
  localparam logic [1:0] MCPU_LDERR_CSUM     = 2'b01;
  localparam logic [1:0] MCPU_LDERR_TIMEOUT  = 2'b10;
endpackage

// File: rtl/mcpu_loader_timer.sv
// mcpu_loader_timer: inter-byte idle counter; expire fires on the edge the count reaches TIMEOUT_CYCLES
module mcpu_loader_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] r_cnt;
  // an accepted byte (clear) always beats an expiry in the same cycle
  assign expire = enable & ~clear & (r_cnt == W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset || clear) r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/mcpu_irom_loader.sv
// mcpu_irom_loader: framed byte stream to IROM write strobes, halting the CPU while a frame loads
module mcpu_irom_loader
  import mcpu_irom_loader_pkg::*;
#(
  parameter int         IROM_ADDR_BITS = 14,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = MCPU_LOADER_SYNC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      irom_we,
  output logic [IROM_ADDR_BITS-1:0] irom_waddr,
  output logic [7:0]                irom_wdata,
  output logic                      cpu_halt,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code
);
  state_t                    r_state, w_next;
  logic [7:0]                r_hi, r_sum;
  logic [15:0]               r_left;
  logic [IROM_ADDR_BITS-1:0] r_addr;
  logic                      w_xfer, w_expire;
  logic [15:0]               w_word;
  logic [7:0]                w_sum;
  assign in_ready = 1'b1;
  assign w_xfer   = in_valid;
  assign w_word   = {r_hi, in_data};
  assign w_sum    = r_sum + in_data;
  mcpu_loader_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_xfer),
    .enable (r_state != S_IDLE),
    .expire (w_expire)
  );
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_expire) w_next = S_IDLE;
    else if (w_xfer) begin
      unique case (r_state)
        S_IDLE:   w_next = (in_data == SYNC_BYTE) ? S_ADDR_H : S_IDLE;
        S_ADDR_H: w_next = S_ADDR_L;
        S_ADDR_L: w_next = S_LEN_H;
        S_LEN_H:  w_next = S_LEN_L;
        S_LEN_L:  w_next = (w_word == 16'd0) ? S_CSUM : S_DATA;
        S_DATA:   w_next = (r_left == 16'd1) ? S_CSUM : S_DATA;
        S_CSUM:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi       <= '0;
      r_sum      <= '0;
      r_left     <= '0;
      r_addr     <= '0;
      irom_we    <= 1'b0;
      irom_waddr <= '0;
      irom_wdata <= '0;
      cpu_halt   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= MCPU_LDERR_NONE;
    end else begin
      irom_we <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      if (w_expire) begin
        err      <= 1'b1;
        err_code <= MCPU_LDERR_TIMEOUT;
        cpu_halt <= 1'b0;
      end else if (w_xfer) begin
        r_sum <= (r_state == S_IDLE) ? 8'd0 : w_sum;
        unique case (r_state)
          S_IDLE:   if (in_data == SYNC_BYTE) cpu_halt <= 1'b1;
          S_ADDR_H: r_hi <= in_data;
          S_ADDR_L: r_addr <= IROM_ADDR_BITS'(w_word);
          S_LEN_H:  r_hi <= in_data;
          S_LEN_L:  r_left <= w_word;
          S_DATA: begin
            irom_we    <= 1'b1;
            irom_waddr <= r_addr;
            irom_wdata <= in_data;
            r_addr     <= r_addr + 1'b1;
            r_left     <= r_left - 16'd1;
          end
          S_CSUM: begin
            done     <= (w_sum == 8'd0);
            err      <= (w_sum != 8'd0);
            err_code <= (w_sum == 8'd0) ? err_code : MCPU_LDERR_CSUM;
            cpu_halt <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mcpu_irom_loader.sv
// tb_mcpu_irom_loader: directed frames with hand-computed writes, checksums, timeout and reset recovery
module tb_mcpu_irom_loader;
  localparam int AB = 14;
  localparam int TO = 8;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, irom_we, cpu_halt, done, err;
  logic [AB-1:0] irom_waddr;
  logic [7:0]    irom_wdata;
  logic [1:0]    err_code;
  logic [7:0]    mem [0:(1<<AB)-1];
  int            n_checks = 0;
  int            n_fail = 0;
  mcpu_irom_loader #(.IROM_ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .irom_we    (irom_we),
    .irom_waddr (irom_waddr),
    .irom_wdata (irom_wdata),
    .cpu_halt   (cpu_halt),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (irom_we) mem[irom_waddr] <= irom_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic send_hdr(input logic [15:0] a, input logic [15:0] len);
    send(8'hA5, 0);
    chk("halt_after_sync", cpu_halt, 1);
    send(a[15:8], 0);
    send(a[7:0], 0);
    send(len[15:8], 0);
    send(len[7:0], 0);
  endtask
  task automatic send_wr(input logic [7:0] b, input logic [AB-1:0] a, input string tag);
    send(b, 0);
    chk({tag, "_we"}, irom_we, 1);
    chk({tag, "_addr"}, irom_waddr, a);
    chk({tag, "_data"}, irom_wdata, b);
    chk({tag, "_halt"}, cpu_halt, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", irom_we, 0);
    chk("rst_waddr", irom_waddr, 0);
    chk("rst_wdata", irom_wdata, 0);
    chk("rst_halt", cpu_halt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    reset = 1'b0;
    // basic frame: sum 01+00+00+03+11+22+33 = 6A, so checksum byte 96
    send_hdr(16'h0100, 16'd3);
    send_wr(8'h11, 14'h100, "f1w0");
    send_wr(8'h22, 14'h101, "f1w1");
    send_wr(8'h33, 14'h102, "f1w2");
    send(8'h96, 0);
    chk("f1_done", done, 1);
    chk("f1_err", err, 0);
    chk("f1_halt", cpu_halt, 0);
    chk("f1_we", irom_we, 0);
    chk("f1_hold_data", irom_wdata, 8'h33);
    @(posedge clk); #1;
    chk("f1_done_pulse", done, 0);
    send_hdr(16'h0100, 16'd3);
    send_wr(8'h11, 14'h100, "f2w0");
    send_wr(8'h22, 14'h101, "f2w1");
    send_wr(8'h33, 14'h102, "f2w2");
    send(8'h00, 0);
    chk("f2_err", err, 1);
    chk("f2_code", err_code, 2'b01);
    chk("f2_done", done, 0);
    chk("f2_halt", cpu_halt, 0);
    // wrap: sum 3F+FE+00+03+AA+BB+CC = 71, checksum 8F
    send_hdr(16'h3FFE, 16'd3);
    send_wr(8'hAA, 14'h3FFE, "f3w0");
    send_wr(8'hBB, 14'h3FFF, "f3w1");
    send_wr(8'hCC, 14'h0000, "f3w2");
    send(8'h8F, 0);
    chk("f3_done", done, 1);
    chk("f3_err", err, 0);
    send(8'hA5, 0);
    send(8'h00, 0); chk("f4_we_a", irom_we, 0);
    send(8'h10, 0); chk("f4_we_b", irom_we, 0);
    send(8'h00, 0); chk("f4_we_c", irom_we, 0);
    send(8'h00, 0); chk("f4_we_d", irom_we, 0);
    send(8'hF0, 0);
    chk("f4_done", done, 1);
    chk("f4_we_e", irom_we, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    chk("f5_garbage_halt", cpu_halt, 0);
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h20, 0);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("f5_no_err_early", err, 0);
    chk("f5_halt_early", cpu_halt, 1);
    @(posedge clk); #1;
    chk("f5_err", err, 1);
    chk("f5_code", err_code, 2'b10);
    chk("f5_halt", cpu_halt, 0);
    @(posedge clk); #1;
    chk("f5_err_pulse", err, 0);
    chk("f5_code_hold", err_code, 2'b10);
    // sum 00+30+00+01+5A = 8B, checksum 75
    send_hdr(16'h0030, 16'd1);
    send_wr(8'h5A, 14'h030, "f5w0");
    send(8'h75, 0);
    chk("f5b_done", done, 1);
    send_hdr(16'h0040, 16'd4);
    send_wr(8'h01, 14'h040, "f6w0");
    send_wr(8'h02, 14'h041, "f6w1");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("f6_rst_halt", cpu_halt, 0);
    chk("f6_rst_we", irom_we, 0);
    chk("f6_rst_waddr", irom_waddr, 0);
    chk("f6_rst_done", done, 0);
    chk("f6_rst_err", err, 0);
    chk("f6_rst_code", err_code, 0);
    // gapped frame: sum 00+50+00+04+D1+D2+D3+D4 = 9E, checksum 62
    send(8'hA5, $urandom_range(0, 3));
    send(8'h00, $urandom_range(0, 3));
    send(8'h50, $urandom_range(0, 3));
    send(8'h00, $urandom_range(0, 3));
    send(8'h04, $urandom_range(0, 3));
    for (int i = 0; i < 4; i++) send(8'hD1 + 8'(i), $urandom_range(0, 3));
    send(8'h62, $urandom_range(0, 3));
    chk("f7_done", done, 1);
    chk("f7_err", err, 0);
    repeat (2) @(posedge clk); #1;
    chk("img_100", mem[14'h100], 8'h11);
    chk("img_102", mem[14'h102], 8'h33);
    chk("img_3fff", mem[14'h3FFF], 8'hBB);
    chk("img_000", mem[14'h000], 8'hCC);
    chk("img_030", mem[14'h030], 8'h5A);
    chk("img_041", mem[14'h041], 8'h02);
    chk("img_050", mem[14'h050], 8'hD1);
    chk("img_051", mem[14'h051], 8'hD2);
    chk("img_052", mem[14'h052], 8'hD3);
    chk("img_053", mem[14'h053], 8'hD4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
